// File: rtl/csa_multiword_sequencer.sv
// csa_multiword_sequencer: one 4-bit carry-select slice time-shared LSB-first across NIBBLES nibbles; define SUB_MODE_EN to add a subtract input
module csa_multiword_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4*NIBBLES,
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SUB_MODE_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [W-1:0] sum,
  output logic         cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, sub_r, sub_in, last;
  logic [3:0] an, bn;
  logic [4:0] r0, r1, r;
`ifdef SUB_MODE_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  assign last = idx == IW'(NIBBLES-1);
  // carry-select slice: both carry outcomes computed, the held carry picks one
  always_comb begin
    an = a_r[4*idx +: 4];
    bn = b_r[4*idx +: 4] ^ {4{sub_r}};
    r0 = {1'b0, an} + {1'b0, bn};
    r1 = r0 + 5'd1;
    r = carry ? r1 : r0;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs
  always_comb begin
    state_n = state;
    start_ready = state == IDLE;
    busy = state == RUN;
    done_valid = state == DONE;
    state_n = state == IDLE ? (start_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (done_ready ? IDLE : DONE);
  end
  // operand capture at accept, then one nibble per RUN cycle
  always_ff @(posedge clk)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (start_ready && start_valid) begin
      a_r <= a;
      b_r <= b;
      sub_r <= sub_in;
      carry <= sub_in | cin;
      idx <= '0;
      sum <= '0;
    end else if (busy) begin
      sum[4*idx +: 4] <= r[3:0];
      carry <= r[4];
      if (last) cout <= r[4];
      else idx <= idx + 1'b1;
    end
endmodule
